// File: rtl/tron_pkg.sv
// ---------------------------------------------------------------------------
// tron_pkg
// Definitions shared by the plot arbiter, its clear sweeper, the bus
// interface and the bench: screen geometry, coordinate widths, colour
// constants, state and player encodings, and the coordinate range check.
// ---------------------------------------------------------------------------
package tron_pkg;

  // Coordinate widths of the vga_adapter write port.
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;

  // Default screen geometry: 160 x 120 pixels.
  localparam logic [XW-1:0] X_MAX = 8'd160;
  localparam logic [YW-1:0] Y_MAX = 7'd120;

  // Colours, packed as {r,g,b}.
  localparam logic [2:0] BLACK     = 3'b000;
  localparam logic [2:0] P1_COLOUR = 3'b100;
  localparam logic [2:0] P2_COLOUR = 3'b010;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_e;

  // True when (x, y) lies on a screen of xm columns and ym rows.
  function automatic logic in_range(input logic [XW-1:0] x,
                                    input logic [YW-1:0] y,
                                    input logic [XW-1:0] xm,
                                    input logic [YW-1:0] ym);
    return (x < xm) && (y < ym);
  endfunction

endpackage

// File: rtl/tron_plot_arbiter_if.sv
// ---------------------------------------------------------------------------
// tron_plot_arbiter_if
// Groups the plot arbiter's bus signals.
//   Player side:  clear_start, req/x/y/col for each player, and ack for each
//                 player.
//   VGA side:     x_out, y_out, colour_out, plot.
//   Status:       clear_busy, clear_done, oob_drop.
// Modports:
//   master -- the requesters and the VGA sink (the bench in simulation).
//   slave  -- the arbiter.
// ---------------------------------------------------------------------------
interface tron_plot_arbiter_if;
  import tron_pkg::*;

  logic          clear_start;
  logic          req_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic [2:0]    col_p1;
  logic          req_p2;
  logic [XW-1:0] x_p2;
  logic [YW-1:0] y_p2;
  logic [2:0]    col_p2;
  logic          ack_p1;
  logic          ack_p2;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [2:0]    colour_out;
  logic          plot;
  logic          clear_busy;
  logic          clear_done;
  logic          oob_drop;

  modport master (
    output clear_start,
    output req_p1, x_p1, y_p1, col_p1,
    output req_p2, x_p2, y_p2, col_p2,
    input  ack_p1, ack_p2,
    input  x_out, y_out, colour_out, plot,
    input  clear_busy, clear_done, oob_drop
  );

  modport slave (
    input  clear_start,
    input  req_p1, x_p1, y_p1, col_p1,
    input  req_p2, x_p2, y_p2, col_p2,
    output ack_p1, ack_p2,
    output x_out, y_out, colour_out, plot,
    output clear_busy, clear_done, oob_drop
  );

endinterface

// File: rtl/tron_clear_sweeper.sv
// ---------------------------------------------------------------------------
// tron_clear_sweeper
// Raster counter for the full-screen clear. A start pulse loads (0,0) and
// raises busy. The counter then advances one pixel per cycle, x first, until
// it has covered (X_MAX-1, Y_MAX-1). On the cycle after the last pixel is
// presented, busy drops and done pulses for one cycle.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   start_i      begin a sweep; restarts from (0,0) if already busy
//   x_o, y_o     current pixel, valid while busy_o is high
//   busy_o       sweep in progress
//   done_o       one-cycle pulse after the last pixel
// ---------------------------------------------------------------------------
module tron_clear_sweeper
  import tron_pkg::*;
#(
  parameter logic [XW-1:0] X_MAX = tron_pkg::X_MAX,
  parameter logic [YW-1:0] Y_MAX = tron_pkg::Y_MAX
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          busy_o,
  output logic          done_o
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          busy_q;
  logic          done_q;
  logic          x_wrap_s;
  logic          last_s;

  // End of the current row, and the final pixel of the screen.
  assign x_wrap_s = (x_q == (X_MAX - 8'd1));
  assign last_s   = busy_q && x_wrap_s && (y_q == (Y_MAX - 7'd1));

  // Raster counter with busy flag and end-of-sweep pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= 8'd0;
      y_q    <= 7'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      x_q    <= 8'd0;
      y_q    <= 7'd0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      done_q <= last_s;
      if (last_s) begin
        x_q    <= 8'd0;
        y_q    <= 7'd0;
        busy_q <= 1'b0;
      end else if (x_wrap_s) begin
        x_q <= 8'd0;
        y_q <= y_q + 7'd1;
      end else begin
        x_q <= x_q + 8'd1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/tron_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tron_plot_arbiter
// Shares the single vga_adapter write port between two player trail plotters
// and the full-screen clear engine. Players are served round-robin. A grant
// whose coordinates fall off-screen is still acknowledged, but it raises
// oob_drop instead of plot. All bus outputs are registered: a decision taken
// at a clock edge drives plot, x/y/colour and ack during the following cycle.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     tron_plot_arbiter_if.slave (player requests/acks, VGA write
//           port, clear control and status)
// ---------------------------------------------------------------------------
module tron_plot_arbiter
  import tron_pkg::*;
#(
  parameter logic [XW-1:0] X_MAX     = tron_pkg::X_MAX,
  parameter logic [YW-1:0] Y_MAX     = tron_pkg::Y_MAX,
  parameter logic [2:0]    BG_COLOUR = BLACK
) (
  input  logic                 clk,
  input  logic                 resetn,
  tron_plot_arbiter_if.slave   bus
);

  state_e        state_q;
  player_e       last_grant_q;
  logic          ack_p1_q;
  logic          ack_p2_q;
  logic [XW-1:0] x_out_q;
  logic [YW-1:0] y_out_q;
  logic [2:0]    colour_q;
  logic          plot_q;
  logic          clear_busy_q;
  logic          clear_done_q;
  logic          oob_drop_q;

  logic          elig_p1_s;
  logic          elig_p2_s;
  logic          grant_s;
  player_e       gsel_s;
  logic [XW-1:0] gx_s;
  logic [YW-1:0] gy_s;
  logic [2:0]    gcol_s;
  logic          gin_range_s;

  logic          sw_start_s;
  logic [XW-1:0] sw_x_s;
  logic [YW-1:0] sw_y_s;
  logic          sw_busy_s;
  logic          sw_done_s;

  // A player whose ack is still high is masked, because its req may not
  // have dropped yet. Without the mask it would receive a second grant.
  assign elig_p1_s = bus.req_p1 && !ack_p1_q;
  assign elig_p2_s = bus.req_p2 && !ack_p2_q;

  // Round-robin pick: on a tie, the player that was not granted last wins.
  always_comb begin
    grant_s = 1'b0;
    gsel_s  = P1;
    if (elig_p1_s && elig_p2_s) begin
      grant_s = 1'b1;
      gsel_s  = (last_grant_q == P1) ? P2 : P1;
    end else if (elig_p1_s) begin
      grant_s = 1'b1;
      gsel_s  = P1;
    end else if (elig_p2_s) begin
      grant_s = 1'b1;
      gsel_s  = P2;
    end else begin
      grant_s = 1'b0;
      gsel_s  = P1;
    end
  end

  // Coordinate and colour mux for the granted player.
  always_comb begin
    gx_s   = bus.x_p1;
    gy_s   = bus.y_p1;
    gcol_s = bus.col_p1;
    if (gsel_s == P2) begin
      gx_s   = bus.x_p2;
      gy_s   = bus.y_p2;
      gcol_s = bus.col_p2;
    end else begin
      gx_s   = bus.x_p1;
      gy_s   = bus.y_p1;
      gcol_s = bus.col_p1;
    end
  end

  assign gin_range_s = in_range(gx_s, gy_s, X_MAX, Y_MAX);

  // A clear may start only from IDLE, so clear_start during a sweep is ignored.
  assign sw_start_s = (state_q == IDLE) && bus.clear_start;

  tron_clear_sweeper #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_sweeper (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (sw_start_s),
    .x_o     (sw_x_s),
    .y_o     (sw_y_s),
    .busy_o  (sw_busy_s),
    .done_o  (sw_done_s)
  );

  // Arbiter FSM with registered bus outputs. ack, plot, oob and done are
  // single-cycle pulses; coordinates and colour hold between writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= P2;
      ack_p1_q     <= 1'b0;
      ack_p2_q     <= 1'b0;
      x_out_q      <= 8'd0;
      y_out_q      <= 7'd0;
      colour_q     <= 3'b000;
      plot_q       <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      oob_drop_q   <= 1'b0;
    end else begin
      ack_p1_q     <= 1'b0;
      ack_p2_q     <= 1'b0;
      plot_q       <= 1'b0;
      oob_drop_q   <= 1'b0;
      clear_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clear_start) begin
            state_q      <= CLEAR;
            clear_busy_q <= 1'b1;
          end else if (grant_s) begin
            last_grant_q <= gsel_s;
            ack_p1_q     <= (gsel_s == P1);
            ack_p2_q     <= (gsel_s == P2);
            x_out_q      <= gx_s;
            y_out_q      <= gy_s;
            colour_q     <= gcol_s;
            plot_q       <= gin_range_s;
            oob_drop_q   <= !gin_range_s;
          end else begin
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          // The sweeper's done pulse arrives one cycle after its last pixel.
          if (sw_done_s) begin
            state_q      <= IDLE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            plot_q   <= sw_busy_s;
            x_out_q  <= sw_x_s;
            y_out_q  <= sw_y_s;
            colour_q <= BG_COLOUR;
          end
        end
        default: begin
          state_q      <= IDLE;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_p1     = ack_p1_q;
  assign bus.ack_p2     = ack_p2_q;
  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_q;
  assign bus.plot       = plot_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.clear_done = clear_done_q;
  assign bus.oob_drop   = oob_drop_q;

endmodule

// File: tb/tb_tron_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tron_plot_arbiter
// Directed bench for tron_plot_arbiter. Inputs are driven 1 ns after each
// rising edge, and outputs are sampled at the same point. Every output is
// packed into one vector {ack_p1, ack_p2, plot, oob_drop, clear_busy,
// clear_done, colour(3), y(7), x(8)} and compared with a hand-computed value.
// ---------------------------------------------------------------------------
module tb_tron_plot_arbiter;
  import tron_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  tron_plot_arbiter_if bus_if();

  tron_plot_arbiter #(
    .X_MAX     (8'd160),
    .Y_MAX     (7'd120),
    .BG_COLOUR (3'b000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] outs();
    return {bus_if.ack_p1, bus_if.ack_p2, bus_if.plot, bus_if.oob_drop,
            bus_if.clear_busy, bus_if.clear_done, bus_if.colour_out,
            bus_if.y_out, bus_if.x_out};
  endfunction

  function automatic logic [23:0] pack(input logic a1, input logic a2,
                                       input logic p, input logic o,
                                       input logic b, input logic d,
                                       input logic [2:0] c,
                                       input logic [6:0] y,
                                       input logic [7:0] x);
    return {a1, a2, p, o, b, d, c, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nbad;
    int ndone;
    logic [7:0] ex;
    logic [6:0] ey;

    resetn = 1'b0;
    bus_if.clear_start = 1'b0;
    bus_if.req_p1 = 1'b0; bus_if.x_p1 = 8'd0; bus_if.y_p1 = 7'd0; bus_if.col_p1 = 3'b000;
    bus_if.req_p2 = 1'b0; bus_if.x_p2 = 8'd0; bus_if.y_p2 = 7'd0; bus_if.col_p2 = 3'b000;
    tick();
    tick();
    chk("reset_outputs", 32'(outs()), 32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_after_reset", 32'(outs()), 32'd0);

    // Single player 1 request, 1-cycle latency, then masked while ack is high.
    bus_if.req_p1 = 1'b1; bus_if.x_p1 = 8'd10; bus_if.y_p1 = 7'd20; bus_if.col_p1 = 3'b100;
    tick();
    chk("p1_first_plot", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 7'd20, 8'd10)));
    tick();
    chk("p1_no_double_grant", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 7'd20, 8'd10)));
    bus_if.req_p1 = 1'b0;

    // After reset, last_grant is P2, so P1 wins the first tie.
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(outs()), 32'd0);
    tick();
    resetn = 1'b1;
    bus_if.req_p1 = 1'b1; bus_if.x_p1 = 8'd1; bus_if.y_p1 = 7'd2; bus_if.col_p1 = P1_COLOUR;
    bus_if.req_p2 = 1'b1; bus_if.x_p2 = 8'd3; bus_if.y_p2 = 7'd4; bus_if.col_p2 = P2_COLOUR;
    tick();
    chk("rr_grant1_p1", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 7'd2, 8'd1)));
    tick();
    chk("rr_grant2_p2", 32'(outs()), 32'(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 7'd4, 8'd3)));
    tick();
    chk("rr_grant3_p1", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 7'd2, 8'd1)));
    tick();
    chk("rr_grant4_p2", 32'(outs()), 32'(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 7'd4, 8'd3)));
    bus_if.req_p1 = 1'b0;
    bus_if.req_p2 = 1'b0;
    tick();
    chk("no_grant_hold", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 7'd4, 8'd3)));

    // Range boundaries.
    bus_if.req_p1 = 1'b1; bus_if.x_p1 = 8'd160; bus_if.y_p1 = 7'd5; bus_if.col_p1 = P1_COLOUR;
    tick();
    chk("oob_x160", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 7'd5, 8'd160)));
    bus_if.req_p1 = 1'b0;
    tick();
    chk("oob_pulse_end", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 7'd5, 8'd160)));
    bus_if.req_p2 = 1'b1; bus_if.x_p2 = 8'd159; bus_if.y_p2 = 7'd119; bus_if.col_p2 = P2_COLOUR;
    tick();
    chk("in_range_corner", 32'(outs()), 32'(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 7'd119, 8'd159)));
    bus_if.req_p2 = 1'b0;
    tick();
    bus_if.req_p2 = 1'b1; bus_if.x_p2 = 8'd0; bus_if.y_p2 = 7'd120;
    tick();
    chk("oob_y120", 32'(outs()), 32'(pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 7'd120, 8'd0)));
    bus_if.req_p2 = 1'b0;
    tick();

    // Full clear. A p2 request arrives mid-sweep, and a stray clear_start is ignored.
    bus_if.clear_start = 1'b1;
    tick();
    chk("clear_start_cycle", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 7'd120, 8'd0)));
    bus_if.clear_start = 1'b0;
    nbad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (i == 100) begin
        bus_if.req_p2 = 1'b1; bus_if.x_p2 = 8'd50; bus_if.y_p2 = 7'd60; bus_if.col_p2 = P2_COLOUR;
      end
      bus_if.clear_start = (i == 200);
      tick();
      ex = 8'(i % 160);
      ey = 7'(i / 160);
      if (outs() !== pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, ey, ex)) nbad++;
      if (i == 0)
        chk("clear_first_pixel", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 7'd0, 8'd0)));
      if (i == 19199)
        chk("clear_last_pixel", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 7'd119, 8'd159)));
    end
    chk("clear_sweep_bad_cycles", 32'(nbad), 32'd0);
    tick();
    chk("clear_done_pulse", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 7'd119, 8'd159)));
    tick();
    chk("pending_p2_after_clear", 32'(outs()), 32'(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 7'd60, 8'd50)));
    bus_if.req_p2 = 1'b0;
    tick();

    // Reset in the middle of a sweep.
    bus_if.clear_start = 1'b1;
    tick();
    bus_if.clear_start = 1'b0;
    repeat (5000) tick();
    chk("midclear_busy", 32'(bus_if.clear_busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midclear_reset_outputs", 32'(outs()), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.clear_done !== 1'b0 || bus_if.plot !== 1'b0) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    bus_if.clear_start = 1'b1;
    tick();
    bus_if.clear_start = 1'b0;
    tick();
    chk("restart_pixel0", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 7'd0, 8'd0)));
    tick();
    chk("restart_pixel1", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 7'd0, 8'd1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
